// File: rtl/board_io_pkg.sv
// Shared board-I/O definitions: FSM state encoding, a debug view of the
// register file, and default sizing for blocks on the board I/O layer.
package board_io_pkg;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_DEPTH      = 8;
    localparam int DEF_DEB_CYCLES = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Debug view: FSM state plus the accepted (debounced) key levels.
    typedef struct packed {
        state_t state;
        logic   wr_level;
        logic   clr_level;
    } dbg_t;

endpackage

// File: rtl/key_debounce.sv
// Debouncer for one synchronised active-low key: the accepted level follows the
// input only after DEB_CYCLES identical samples; press is a 1-cycle 1->0 pulse.
module key_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int                CNT_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_level_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_level   <= 1'b1;
            r_level_d <= 1'b1;
        end else begin
            r_level_d <= r_level;
            // Any sample that agrees with the accepted level restarts the run.
            if (key_n == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= key_n;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level = r_level;
    assign press = r_level_d & ~r_level;

endmodule

// File: rtl/key_regfile.sv
// Key-driven register file: pushbuttons write or clear it, address switches
// select the word shown on rdata. Clear is a one-word-per-cycle sweep.
module key_regfile
    import board_io_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_wr,
    input  logic              key_clr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              wr_ack,
    output logic              wr_drop,
    output dbg_t              dbg
);

    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] r_addr_m;
    logic [ADDR_W-1:0] r_addr_s;
    logic [ADDR_W-1:0] r_addr_prev;
    logic [DATA_W-1:0] r_wdata_m;
    logic [DATA_W-1:0] r_wdata_s;
    logic              r_kwr_m;
    logic              r_kwr_s;
    logic              r_kclr_m;
    logic              r_kclr_s;

    logic              w_wr_level;
    logic              w_wr_press;
    logic              w_clr_level;
    logic              w_clr_press;
    logic              w_addr_chg;

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_busy;
    logic [DATA_W-1:0] r_rdata;
    logic              r_wr_ack;
    logic              r_wr_drop;

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_waddr;
    logic [DATA_W-1:0] w_mem_wdata;

    // Two-flop synchronisers; keys reset to the released level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr_m    <= '0;
            r_addr_s    <= '0;
            r_addr_prev <= '0;
            r_wdata_m   <= '0;
            r_wdata_s   <= '0;
            r_kwr_m     <= 1'b1;
            r_kwr_s     <= 1'b1;
            r_kclr_m    <= 1'b1;
            r_kclr_s    <= 1'b1;
        end else begin
            r_addr_m    <= addr;
            r_addr_s    <= r_addr_m;
            r_addr_prev <= r_addr_s;
            r_wdata_m   <= wdata;
            r_wdata_s   <= r_wdata_m;
            r_kwr_m     <= key_wr;
            r_kwr_s     <= r_kwr_m;
            r_kclr_m    <= key_clr;
            r_kclr_s    <= r_kclr_m;
        end
    end

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_wr (
        .clk   (clk),
        .rst   (rst),
        .key_n (r_kwr_s),
        .level (w_wr_level),
        .press (w_wr_press)
    );

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
        .clk   (clk),
        .rst   (rst),
        .key_n (r_kclr_s),
        .level (w_clr_level),
        .press (w_clr_press)
    );

    assign w_addr_chg = (r_addr_s != r_addr_prev);

    // Single write port: the sweep owns it in CLEAR, a write press in IDLE.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_waddr = r_addr_s;
        w_mem_wdata = r_wdata_s;
        if (r_state == ST_CLEAR) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = r_ptr;
            w_mem_wdata = '0;
        end else if (w_wr_press && !w_clr_press) begin
            w_mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we && !rst) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_CLEAR;
            r_ptr     <= '0;
            r_busy    <= 1'b1;
            r_rdata   <= '0;
            r_wr_ack  <= 1'b0;
            r_wr_drop <= 1'b0;
        end else begin
            r_wr_ack  <= 1'b0;
            r_wr_drop <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_clr_press) begin
                        r_state <= ST_CLEAR;
                        r_ptr   <= '0;
                        r_busy  <= 1'b1;
                    end else if (w_wr_press) begin
                        r_rdata  <= r_wdata_s;
                        r_wr_ack <= 1'b1;
                    end else if (w_addr_chg) begin
                        r_rdata <= r_mem[r_addr_s];
                    end
                end
                ST_CLEAR: begin
                    // rdata is held during the sweep; 0 is right for every address after it.
                    if (w_wr_press) begin
                        r_wr_drop <= 1'b1;
                    end
                    if (r_ptr == PTR_LAST) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_rdata <= '0;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_ptr   <= '0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign rdata         = r_rdata;
    assign busy          = r_busy;
    assign wr_ack        = r_wr_ack;
    assign wr_drop       = r_wr_drop;
    assign dbg.state     = r_state;
    assign dbg.wr_level  = w_wr_level;
    assign dbg.clr_level = w_clr_level;

endmodule

// File: tb/tb_key_regfile.sv
// Bench for key_regfile: directed scenarios plus random writes/reads, checked
// against an array model of the memory and the stated key-to-ack latency.
module tb_key_regfile;
    import board_io_pkg::*;

    localparam int DATA_W  = 8;
    localparam int DEPTH   = 8;
    localparam int ADDR_W  = 3;
    localparam int WR_LAT  = 7;   // 2 sync + 4 debounce + 1 edge/commit
    localparam int SWEEP   = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              key_wr;
    logic              key_clr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              wr_ack;
    logic              wr_drop;
    dbg_t              dbg;

    int n_tests = 0;
    int n_fail  = 0;
    int ack_cnt = 0;
    int drop_cnt = 0;
    logic [DATA_W-1:0] model_mem [DEPTH];

    always #5 clk = ~clk;

    key_regfile #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DEB_CYCLES(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .key_wr  (key_wr),
        .key_clr (key_clr),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .busy    (busy),
        .wr_ack  (wr_ack),
        .wr_drop (wr_drop),
        .dbg     (dbg)
    );

    always @(negedge clk) begin
        if (wr_ack)  ack_cnt  <= ack_cnt + 1;
        if (wr_drop) drop_cnt <= drop_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    endtask

    // Counts edges from the first busy cycle until busy drops; 0 if it never rises.
    task automatic measure_sweep(output int len);
        int t;
        t = 0;
        len = 0;
        while (!busy && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (busy) begin
            do begin
                @(posedge clk); #1;
                len++;
            end while (busy && len < 50);
        end
    endtask

    task automatic check_read(input int a);
        @(negedge clk);
        addr = ADDR_W'(a);
        repeat (5) @(negedge clk);
        check($sformatf("read_a%0d", a), 32'(rdata), 32'(model_mem[a]));
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            @(negedge clk);
            addr = ADDR_W'(a);
            repeat (5) @(negedge clk);
            check($sformatf("%s_a%0d", tag, a), 32'(rdata), 32'(model_mem[a]));
        end
    endtask

    // Press key_wr (optionally with a bounce prefix), check latency and one ack.
    task automatic do_write(input int a, input logic [DATA_W-1:0] d,
                            input int extra_hold, input bit bounce);
        int a0, lat;
        bit found;
        @(negedge clk);
        addr  = ADDR_W'(a);
        wdata = d;
        repeat (5) @(negedge clk);
        a0 = ack_cnt;
        if (bounce) begin
            for (int i = 0; i < 6; i++) begin
                key_wr = (i % 2 == 0) ? 1'b0 : 1'b1;
                repeat (2) @(negedge clk);
            end
        end
        key_wr = 1'b0;
        lat = 0;
        found = 1'b0;
        while (!found && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (wr_ack) begin
                found = 1'b1;
                check("wr_rdata_at_ack", 32'(rdata), 32'(d));
            end
        end
        check("wr_latency", 32'(lat), 32'(WR_LAT));
        repeat (extra_hold) @(negedge clk);
        key_wr = 1'b1;
        repeat (12) @(negedge clk);
        check("wr_ack_count", 32'(ack_cnt - a0), 32'd1);
        model_mem[a] = d;
    endtask

    initial begin
        int len, a0, d0;
        rst = 1'b1; key_wr = 1'b1; key_clr = 1'b1; addr = '0; wdata = '0;
        model_clear();
        repeat (3) @(negedge clk);
        check("rst_busy",  32'(busy), 32'd1);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_ack",   32'(wr_ack), 32'd0);
        check("rst_drop",  32'(wr_drop), 32'd0);
        check("rst_state", 32'(dbg.state), 32'(ST_CLEAR));

        // 1: power-up sweep
        rst = 1'b0;
        measure_sweep(len);
        check("init_sweep_len", 32'(len), 32'(SWEEP));
        check("init_rdata", 32'(rdata), 32'd0);
        check("init_state", 32'(dbg.state), 32'(ST_IDLE));
        read_all("init_read");

        // 2: single write held 10 cycles, then address round trip
        do_write(3, 8'hA5, 3, 1'b0);
        check_read(5);
        check("read5_zero", 32'(rdata), 32'h00);
        check_read(3);
        check("read3_a5", 32'(rdata), 32'hA5);

        // 3: bouncing key
        do_write(6, DATA_W'($urandom_range(1, 255)), 4, 1'b1);
        check_read(6);

        // Random writes and reads against the array model
        for (int i = 0; i < 10; i++) begin
            do_write($urandom_range(0, DEPTH - 1), DATA_W'($urandom), $urandom_range(0, 5), 1'b0);
        end
        for (int i = 0; i < 10; i++) check_read($urandom_range(0, DEPTH - 1));

        // 4: fill with 0x11, clear, write press during the sweep is dropped
        for (int a = 0; a < DEPTH; a++) do_write(a, 8'h11, 1, 1'b0);
        read_all("fill_read");
        a0 = ack_cnt;
        d0 = drop_cnt;
        @(negedge clk);
        key_clr = 1'b0;
        repeat (2) @(negedge clk);
        key_wr = 1'b0;
        measure_sweep(len);
        check("clr_sweep_len", 32'(len), 32'(SWEEP));
        check("clr_end_rdata", 32'(rdata), 32'd0);
        @(negedge clk);
        key_clr = 1'b1;
        key_wr  = 1'b1;
        repeat (12) @(negedge clk);
        check("clr_drop_count", 32'(drop_cnt - d0), 32'd1);
        check("clr_ack_count",  32'(ack_cnt - a0), 32'd0);
        model_clear();
        read_all("clr_read");

        // 5: coincident clear and write presses
        do_write(1, 8'h77, 2, 1'b0);
        a0 = ack_cnt;
        d0 = drop_cnt;
        @(negedge clk);
        key_clr = 1'b0;
        key_wr  = 1'b0;
        measure_sweep(len);
        check("coin_sweep_len", 32'(len), 32'(SWEEP));
        @(negedge clk);
        key_clr = 1'b1;
        key_wr  = 1'b1;
        repeat (12) @(negedge clk);
        check("coin_ack_count",  32'(ack_cnt - a0), 32'd0);
        check("coin_drop_count", 32'(drop_cnt - d0), 32'd0);
        model_clear();
        check_read(1);

        // 6: reset in the middle of a sweep restarts it
        do_write(2, 8'h5A, 2, 1'b0);
        @(negedge clk);
        key_clr = 1'b0;
        len = 0;
        while (!busy && len < 50) begin
            @(posedge clk); #1;
            len++;
        end
        key_clr = 1'b1;
        check("rst6_busy_rose", 32'(busy), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("sweep_rdata_held", 32'(rdata), 32'h5A);
        rst = 1'b1;
        #1;
        check("midrst_busy",  32'(busy), 32'd1);
        check("midrst_rdata", 32'(rdata), 32'd0);
        check("midrst_state", 32'(dbg.state), 32'(ST_CLEAR));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        measure_sweep(len);
        check("midrst_sweep_len", 32'(len), 32'(SWEEP));
        check("midrst_end_rdata", 32'(rdata), 32'd0);
        model_clear();
        repeat (10) @(negedge clk);
        read_all("midrst_read");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
